// File: rtl/led_bank.sv
// Memory-mapped LED controller: DATA/MODE/BLINK_DIV/PWM_DUTY registers with
// static, blink and PWM drive modes and selectable pin polarity.
module led_bank #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned PRESCALE   = 50000,
    parameter int unsigned PWM_BITS   = 8,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [3:0]       be,
    input  logic [31:0]      din,
    output logic [31:0]      dout,
    output logic [WIDTH-1:0] led_light
);

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_PWM    = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_t;

    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]    PRE_MAX  = PRE_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] DUTY_RST = PWM_BITS'(32'd1 << (PWM_BITS - 1));

    logic [WIDTH-1:0]    data_q;
    mode_t               mode_q;
    logic [15:0]         div_q;
    logic [PWM_BITS-1:0] duty_q;

    logic [PRE_W-1:0]    pre_cnt;
    logic [15:0]         blk_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                phase;

    logic [31:0]         cur_word;
    logic [31:0]         lane_mask;
    logic [31:0]         wr_word;
    logic                wr_any;
    logic                restart;
    logic                tick;
    logic                pwm_on;
    logic [WIDTH-1:0]    on_vec;

    always_comb begin
        cur_word = '0;
        case (addr)
            2'd0: cur_word = 32'(data_q);
            2'd1: cur_word = {30'd0, mode_q};
            2'd2: cur_word = {16'd0, div_q};
            2'd3: cur_word = 32'(duty_q);
            default: cur_word = '0;
        endcase
        lane_mask = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            lane_mask[8*i +: 8] = {8{be[i]}};
        end
        // Merge keeps unselected lanes of the addressed register intact
        wr_word = (din & lane_mask) | (cur_word & ~lane_mask);
        dout    = cur_word;
    end

    assign wr_any  = we && (be != '0);
    assign restart = wr_any && ((addr == 2'd1) || (addr == 2'd2));
    assign tick    = (pre_cnt == PRE_MAX);
    assign pwm_on  = (pwm_cnt < duty_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            mode_q <= MODE_STATIC;
            div_q  <= 16'hFFFF;
            duty_q <= DUTY_RST;
        end else if (wr_any) begin
            case (addr)
                2'd0: data_q <= wr_word[WIDTH-1:0];
                2'd1: mode_q <= mode_t'(wr_word[1:0]);
                2'd2: div_q  <= wr_word[15:0];
                2'd3: duty_q <= wr_word[PWM_BITS-1:0];
                default: ;
            endcase
        end
    end

    // A MODE/BLINK_DIV write restarts all timing at the same edge; it
    // overrides any tick or toggle that would otherwise land there.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            pre_cnt <= '0;
            blk_cnt <= '0;
            pwm_cnt <= '0;
            phase   <= 1'b1;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (tick) begin
                if (blk_cnt == div_q) begin
                    blk_cnt <= '0;
                    phase   <= ~phase;
                end else begin
                    blk_cnt <= blk_cnt + 16'd1;
                end
            end
        end
    end

    always_comb begin
        on_vec = data_q;
        case (mode_q)
            MODE_BLINK: on_vec = data_q & {WIDTH{phase}};
            MODE_PWM:   on_vec = data_q & {WIDTH{pwm_on}};
            default:    on_vec = data_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_light <= ACTIVE_LOW ? '1 : '0;
        end else begin
            led_light <= ACTIVE_LOW ? ~on_vec : on_vec;
        end
    end

endmodule

// File: tb/tb_led_bank.sv
// Directed self-checking bench for led_bank: three instances cover blink,
// PWM and non-inverted narrow configurations.
module tb_led_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  we;
    logic [1:0]  addr;
    logic [3:0]  be;
    logic [31:0] din;

    logic [31:0] dout0, dout1, dout2;
    logic [31:0] led0, led1;
    logic [7:0]  led2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_bank #(.WIDTH(32), .PRESCALE(4), .PWM_BITS(8), .ACTIVE_LOW(1'b1)) dut0 (
        .clk(clk), .rst(rst), .we(we[0]), .addr(addr), .be(be), .din(din),
        .dout(dout0), .led_light(led0));

    led_bank #(.WIDTH(32), .PRESCALE(4), .PWM_BITS(4), .ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .rst(rst), .we(we[1]), .addr(addr), .be(be), .din(din),
        .dout(dout1), .led_light(led1));

    led_bank #(.WIDTH(8), .PRESCALE(4), .PWM_BITS(8), .ACTIVE_LOW(1'b0)) dut2 (
        .clk(clk), .rst(rst), .we(we[2]), .addr(addr), .be(be), .din(din),
        .dout(dout2), .led_light(led2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int d, input logic [1:0] a, input logic [3:0] b, input logic [31:0] v);
        we       = '0;
        we[d]    = 1'b1;
        addr     = a;
        be       = b;
        din      = v;
        step();
        we       = '0;
        be       = '0;
    endtask

    task automatic pwm_count(input string tag, input int exp);
        int lit = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (led1 == 32'hFFFF_FFF0) lit++;
        end
        chk(tag, 32'(lit), 32'(exp));
    endtask

    initial begin
        rst  = 1'b1;
        we   = '0;
        addr = '0;
        be   = '0;
        din  = '0;
        step();
        step();
        rst = 1'b0;

        chk("reset_led", led0, 32'hFFFF_FFFF);
        addr = 2'd0; #1 chk("reset_data", dout0, 32'h0);
        addr = 2'd1; #1 chk("reset_mode", dout0, 32'h0);
        addr = 2'd2; #1 chk("reset_div",  dout0, 32'h0000_FFFF);
        addr = 2'd3; #1 chk("reset_duty", dout0, 32'h80);

        // byte-enable write and 2-cycle write-to-pin latency
        wr(0, 2'd0, 4'b0101, 32'hAABB_CCDD);
        addr = 2'd0; #1 chk("be_data", dout0, 32'h00BB_00DD);
        chk("be_led_early", led0, 32'hFFFF_FFFF);
        step();
        chk("be_led", led0, 32'hFF44_FF22);

        wr(0, 2'd0, 4'b0000, 32'h1234_5678);
        addr = 2'd0; #1 chk("be0_noop", dout0, 32'h00BB_00DD);

        // blink: PRESCALE=4, BLINK_DIV=1 -> 8 lit, 8 dark
        wr(0, 2'd0, 4'b1111, 32'h1);
        wr(0, 2'd2, 4'b1111, 32'h1);
        wr(0, 2'd1, 4'b1111, 32'h1);
        for (int k = 1; k <= 27; k++) begin
            step();
            chk($sformatf("blink_k%0d", k), led0,
                (((k - 1) / 8) % 2 == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
        end
        wr(0, 2'd2, 4'b0001, 32'h1);
        chk("restart_edge", led0, 32'hFFFF_FFFF);
        for (int j = 1; j <= 9; j++) begin
            step();
            chk($sformatf("restart_j%0d", j), led0,
                (j <= 8) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
        end

        // reserved mode behaves as static
        wr(0, 2'd1, 4'b1111, 32'h3);
        addr = 2'd1; #1 chk("rsvd_read", dout0, 32'h3);
        step();
        step();
        chk("rsvd_static", led0, 32'hFFFF_FFFE);

        // reset has priority over a simultaneous write
        rst   = 1'b1;
        we    = 3'b111;
        addr  = 2'd0;
        be    = 4'b1111;
        din   = 32'h5555_5555;
        step();
        rst = 1'b0;
        we  = '0;
        be  = '0;
        addr = 2'd0; #1 chk("prio_data", dout0, 32'h0);
        addr = 2'd1; #1 chk("prio_mode", dout0, 32'h0);
        addr = 2'd2; #1 chk("prio_div",  dout0, 32'h0000_FFFF);
        chk("prio_led", led0, 32'hFFFF_FFFF);
        addr = 2'd3; #1 chk("prio_duty4", dout1, 32'h8);

        // PWM, PWM_BITS=4
        wr(1, 2'd3, 4'b1111, 32'h4);
        wr(1, 2'd0, 4'b1111, 32'hF);
        wr(1, 2'd1, 4'b1111, 32'h2);
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("pwm4_k%0d", k), led1,
                (k <= 4) ? 32'hFFFF_FFF0 : 32'hFFFF_FFFF);
        end
        pwm_count("pwm4_count", 4);
        wr(1, 2'd3, 4'b1111, 32'h0);
        step();
        pwm_count("pwm0_count", 0);
        wr(1, 2'd3, 4'b1111, 32'hF);
        step();
        pwm_count("pwm15_count", 15);

        // non-inverted 8-bit instance
        chk("al0_reset_led", {24'd0, led2}, 32'h0);
        wr(2, 2'd0, 4'b1111, 32'hFFFF_FFFF);
        addr = 2'd0; #1 chk("al0_data", dout2, 32'hFF);
        step();
        chk("al0_led", {24'd0, led2}, 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
